img_stream_proc: RTL and testbench

//   Streaming per-pixel image processor, the parametrised successor to the fixed-mode RGB reader/processor.

---
 rtl/img_proc_pkg.sv | 27 ++
 rtl/pix_op_lane.sv | 84 ++++++++
 rtl/img_stream_proc.sv | 205 ++++++++++++++++++++
 tb/tb_img_stream_proc.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// Shared definitions for the streaming image processor: operation encodings,
// control FSM states and luma weights used by the weighted grey build.
package img_proc_pkg;

  localparam logic [2:0] MODE_BYPASS  = 3'd0;
  localparam logic [2:0] MODE_BRT_ADD = 3'd1;
  localparam logic [2:0] MODE_BRT_SUB = 3'd2;
  localparam logic [2:0] MODE_GRAY    = 3'd3;
  localparam logic [2:0] MODE_INVERT  = 3'd4;
  localparam logic [2:0] MODE_THRESH  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Weights sum to 256 so the weighted luma is a plain >> 8.
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  function automatic int counter_width(input int span);
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/pix_op_lane.sv
// Combinational single-pixel point operator, one instance per parallel lane.
// Define GRAY_WEIGHTED_EN to use the 77/150/29 luma instead of the (R+G+B)/3 average.
module pix_op_lane #(
  parameter int DW = 8
) (
  input  logic [2:0]    mode,
  input  logic [DW-1:0] value,
  input  logic [DW-1:0] thresh,
  input  logic [DW-1:0] src_r,
  input  logic [DW-1:0] src_g,
  input  logic [DW-1:0] src_b,
  output logic [DW-1:0] res_r,
  output logic [DW-1:0] res_g,
  output logic [DW-1:0] res_b
);
  import img_proc_pkg::*;

  localparam logic [DW-1:0] MAX = '1;

  logic [DW-1:0] luma;
  logic [DW-1:0] binary;

`ifdef GRAY_WEIGHTED_EN
  logic [DW+7:0] luma_sum;

  assign luma_sum = (DW+8)'(LUMA_R) * (DW+8)'(src_r)
                  + (DW+8)'(LUMA_G) * (DW+8)'(src_g)
                  + (DW+8)'(LUMA_B) * (DW+8)'(src_b);
  assign luma     = luma_sum[DW+7:8];
`else
  logic [DW+1:0] gray_sum;

  assign gray_sum = {2'b00, src_r} + {2'b00, src_g} + {2'b00, src_b};
  assign luma     = DW'(gray_sum / (DW+2)'(3));
`endif

  assign binary = (luma > thresh) ? MAX : '0;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DW] ? MAX : sum[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] clamp_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Unknown encodings fall through to the pass-through defaults.
  always_comb begin
    res_r = src_r;
    res_g = src_g;
    res_b = src_b;
    case (mode)
      MODE_BRT_ADD: begin
        res_r = sat_add(src_r, value);
        res_g = sat_add(src_g, value);
        res_b = sat_add(src_b, value);
      end
      MODE_BRT_SUB: begin
        res_r = clamp_sub(src_r, value);
        res_g = clamp_sub(src_g, value);
        res_b = clamp_sub(src_b, value);
      end
      MODE_GRAY: begin
        res_r = luma;
        res_g = luma;
        res_b = luma;
      end
      MODE_INVERT: begin
        res_r = MAX - src_r;
        res_g = MAX - src_g;
        res_b = MAX - src_b;
      end
      MODE_THRESH: begin
        res_r = binary;
        res_g = binary;
        res_b = binary;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/img_stream_proc.sv
// Streaming RGB point processor: PPB pixels per beat through a two-stage
// stall-able pipeline with frame tags. GRAY_WEIGHTED_EN selects weighted luma.
module img_stream_proc
  import img_proc_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int DW     = 8,
  parameter int PPB    = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [2:0]        cfg_mode,
  input  logic [DW-1:0]     cfg_value,
  input  logic [DW-1:0]     cfg_thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PPB*DW-1:0] in_r,
  input  logic [PPB*DW-1:0] in_g,
  input  logic [PPB*DW-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PPB*DW-1:0] out_r,
  output logic [PPB*DW-1:0] out_g,
  output logic [PPB*DW-1:0] out_b,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int BEATS = WIDTH * HEIGHT / PPB;
  localparam int COLS  = WIDTH / PPB;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int COLW  = counter_width(COLS);
  localparam int ROWW  = counter_width(HEIGHT);
  localparam int LW    = PPB * DW;

  state_t state;
  state_t state_next;

  logic [2:0]      mode_q;
  logic [DW-1:0]   value_q;
  logic [DW-1:0]   thresh_q;

  logic [CW-1:0]   in_cnt;
  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;

  logic            s1_valid;
  logic [LW-1:0]   s1_r;
  logic [LW-1:0]   s1_g;
  logic [LW-1:0]   s1_b;
  logic [LW-1:0]   res_r;
  logic [LW-1:0]   res_g;
  logic [LW-1:0]   res_b;

  logic            stall;
  logic            accept;
  logic            last_in;
  logic            out_fire;
  logic            last_col;
  logic            last_row;
  logic            last_out;
  logic            cfg_load;
  logic            running;

  assign stall    = out_valid & ~out_ready;
  assign accept   = in_valid & in_ready;
  assign last_in  = accept & (in_cnt == CW'(BEATS - 1));
  assign out_fire = out_valid & out_ready;
  assign last_col = (col == COLW'(COLS - 1));
  assign last_row = (row == ROWW'(HEIGHT - 1));
  assign last_out = out_fire & last_col & last_row;

  // Control state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing: a start pulse is only honoured from idle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)    state_next = ST_RUN;
      ST_RUN:   if (last_in)  state_next = ST_DRAIN;
      ST_DRAIN: if (last_out) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_load = 1'b0;
    running  = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE:  cfg_load = start;
      ST_RUN: begin
        running = 1'b1;
        busy    = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      default: ;
    endcase
    in_ready = running & (in_cnt < CW'(BEATS)) & ~stall;
  end

  // Configuration is frozen for the whole frame once start is taken.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      mode_q   <= MODE_BYPASS;
      value_q  <= '0;
      thresh_q <= '0;
    end else if (cfg_load) begin
      mode_q   <= cfg_mode;
      value_q  <= cfg_value;
      thresh_q <= cfg_thresh;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      in_cnt <= '0;
    end else if (cfg_load) begin
      in_cnt <= '0;
    end else if (accept) begin
      in_cnt <= in_cnt + CW'(1);
    end
  end

  // Output position follows handshaked beats and returns to 0,0 after the frame.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      col <= '0;
      row <= '0;
    end else if (out_fire) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROWW'(1);
      end else begin
        col <= col + COLW'(1);
      end
    end
  end

  for (genvar k = 0; k < PPB; k++) begin : g_lane
    pix_op_lane #(.DW(DW)) u_lane (
      .mode   (mode_q),
      .value  (value_q),
      .thresh (thresh_q),
      .src_r  (s1_r[k*DW +: DW]),
      .src_g  (s1_g[k*DW +: DW]),
      .src_b  (s1_b[k*DW +: DW]),
      .res_r  (res_r[k*DW +: DW]),
      .res_g  (res_g[k*DW +: DW]),
      .res_b  (res_b[k*DW +: DW])
    );
  end

  // Both stages hold together on a downstream stall, so nothing is lost or repeated.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (!stall) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (accept) begin
        s1_r <= in_r;
        s1_g <= in_g;
        s1_b <= in_b;
      end
      if (s1_valid) begin
        out_r <= res_r;
        out_g <= res_g;
        out_b <= res_b;
      end
    end
  end

  assign out_sof = out_valid & (col == '0) & (row == '0);
  assign out_eol = out_valid & last_col;
  assign out_eof = out_valid & last_col & last_row;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_DRAIN) & last_out;
    end
  end

endmodule

// File: tb/tb_img_stream_proc.sv
// Randomised and directed bench for img_stream_proc on an 8x2 image, checked
// against a per-pixel arithmetic model and a queue of expected beats.
module tb_img_stream_proc;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 2;
  localparam int DW     = 8;
  localparam int PPB    = 2;
  localparam int LW     = PPB * DW;
  localparam int BEATS  = WIDTH * HEIGHT / PPB;
  localparam int COLS   = WIDTH / PPB;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    cfg_mode = 3'd0;
  logic [DW-1:0] cfg_value = '0;
  logic [DW-1:0] cfg_thresh = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_r = '0;
  logic [LW-1:0] in_g = '0;
  logic [LW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW-1:0] out_r;
  logic [LW-1:0] out_g;
  logic [LW-1:0] out_b;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          frame_done;

  always #5 HCLK = ~HCLK;

  img_stream_proc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DW(DW), .PPB(PPB)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .cfg_mode   (cfg_mode),
    .cfg_value  (cfg_value),
    .cfg_thresh (cfg_thresh),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [LW-1:0] r;
    logic [LW-1:0] g;
    logic [LW-1:0] b;
    logic [2:0]    flags;
  } beat_t;

  beat_t exp_q[$];
  beat_t pop_e;
  beat_t push_e;

  int total = 0;
  int bad = 0;
  int cur_mode = 0;
  int cur_val = 0;
  int cur_thr = 0;
  int in_idx = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ov_cyc = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;
  bit fd_pending = 1'b0;
  bit fd_seen = 1'b0;
  bit first_seen = 1'b0;
  bit stalled_prev = 1'b0;
  logic [3*LW+2:0] hold_bus;
  logic [LW-1:0] first_r, first_g, first_b;
  logic [DW-1:0] dir_r[PPB], dir_g[PPB], dir_b[PPB];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, required);
    end
  endtask

  // Reference rules for one pixel, straight from the operation definitions.
  function automatic void model_px(input int m, input int v, input int t,
                                   input int r, input int g, input int b,
                                   output int yr, output int yg, output int yb);
    int y;
`ifdef GRAY_WEIGHTED_EN
    y = (77 * r + 150 * g + 29 * b) / 256;
`else
    y = (r + g + b) / 3;
`endif
    yr = r; yg = g; yb = b;
    case (m)
      1: begin
        yr = (r + v > 255) ? 255 : r + v;
        yg = (g + v > 255) ? 255 : g + v;
        yb = (b + v > 255) ? 255 : b + v;
      end
      2: begin
        yr = (r < v) ? 0 : r - v;
        yg = (g < v) ? 0 : g - v;
        yb = (b < v) ? 0 : b - v;
      end
      3: begin yr = y; yg = y; yb = y; end
      4: begin yr = 255 - r; yg = 255 - g; yb = 255 - b; end
      5: begin
        yr = (y > t) ? 255 : 0;
        yg = yr; yb = yr;
      end
      default: ;
    endcase
  endfunction

  initial forever begin
    @(posedge HCLK);
    #1;
    out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
  end

  // Single compare process: frame_done timing, stall stability, output beats, model updates.
  initial forever begin
    @(negedge HCLK);
    cyc++;
    if (mon_en) begin
      checkOutput("frame_done", frame_done, fd_pending);
      if (frame_done) fd_seen = 1'b1;
      fd_pending = 1'b0;
      if (stalled_prev)
        checkOutput("stall_hold", {out_r, out_g, out_b, out_sof, out_eol, out_eof}, hold_bus);
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        ov_cyc  = cyc;
        first_r = out_r;
        first_g = out_g;
        first_b = out_b;
      end
      if (out_valid && !out_ready) checkOutput("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("queue_depth", exp_q.size(), 1);
        end else begin
          pop_e = exp_q.pop_front();
          checkOutput("out_r", out_r, pop_e.r);
          checkOutput("out_g", out_g, pop_e.g);
          checkOutput("out_b", out_b, pop_e.b);
          checkOutput("flags", {out_sof, out_eol, out_eof}, pop_e.flags);
          if (pop_e.flags[0]) fd_pending = 1'b1;
        end
      end
      stalled_prev = out_valid && !out_ready;
      hold_bus = {out_r, out_g, out_b, out_sof, out_eol, out_eof};
      if (in_valid && in_ready) begin
        for (int k = 0; k < PPB; k++) begin
          int yr, yg, yb;
          model_px(cur_mode, cur_val, cur_thr,
                   int'(in_r[k*DW +: DW]), int'(in_g[k*DW +: DW]), int'(in_b[k*DW +: DW]),
                   yr, yg, yb);
          push_e.r[k*DW +: DW] = DW'(yr);
          push_e.g[k*DW +: DW] = DW'(yg);
          push_e.b[k*DW +: DW] = DW'(yb);
        end
        push_e.flags = {in_idx == 0, (in_idx % COLS) == COLS - 1, in_idx == BEATS - 1};
        if (in_idx == 0) acc_cyc = cyc;
        exp_q.push_back(push_e);
        in_idx = (in_idx + 1) % BEATS;
      end
    end
  end

  task automatic send_beat(input bit use_dir, input bit gaps);
    bit hs = 1'b0;
    if (gaps) repeat ($urandom % 3) begin
      in_valid = 1'b0;
      @(posedge HCLK);
      #1;
    end
    in_valid = 1'b1;
    for (int k = 0; k < PPB; k++) begin
      in_r[k*DW +: DW] = use_dir ? dir_r[k] : DW'($urandom);
      in_g[k*DW +: DW] = use_dir ? dir_g[k] : DW'($urandom);
      in_b[k*DW +: DW] = use_dir ? dir_b[k] : DW'($urandom);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      hs = in_ready;
      @(posedge HCLK);
      #1;
      if (hs) break;
    end
    checkOutput("accept_in_time", hs, 1);
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input int mode, input int val, input int thr);
    @(posedge HCLK);
    #1;
    start = 1'b1;
    cfg_mode = 3'(mode);
    cfg_value = DW'(val);
    cfg_thresh = DW'(thr);
    cur_mode = mode;
    cur_val = val;
    cur_thr = thr;
    first_seen = 1'b0;
    fd_seen = 1'b0;
    @(posedge HCLK);
    #1;
    start = 1'b0;
    cfg_mode = 3'($urandom);
    cfg_value = DW'($urandom);
    cfg_thresh = DW'($urandom);
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic applyStimulus(input int mode, input int val, input int thr,
                               input bit use_dir, input bit gaps);
    start_frame(mode, val, thr);
    for (int n = 0; n < BEATS; n++) send_beat(use_dir, gaps);
    for (int i = 0; i < 300 && !(fd_seen && !busy); i++) @(negedge HCLK);
    checkOutput("frame_complete", fd_seen && !busy, 1);
    checkOutput("first_latency", ov_cyc - acc_cyc, 2);
    checkOutput("queue_empty", exp_q.size(), 0);
  endtask

  task automatic set_dir(input int l, input int r, input int g, input int b);
    dir_r[l] = DW'(r);
    dir_g[l] = DW'(g);
    dir_b[l] = DW'(b);
  endtask

  task automatic check_zero_outputs(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_flags"}, {out_sof, out_eol, out_eof}, 0);
    checkOutput({tag, "_data"}, {out_r, out_g, out_b}, 0);
  endtask

  initial begin
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_zero_outputs("reset");
    mon_en = 1'b1;

    set_dir(0, 200, 10, 155); set_dir(1, 200, 10, 155);
    applyStimulus(1, 100, 0, 1'b1, 1'b0);
    checkOutput("pin_add_r", first_r, 16'hFFFF);
    checkOutput("pin_add_g", first_g, 16'h6E6E);
    checkOutput("pin_add_b", first_b, 16'hFFFF);

    set_dir(0, 50, 100, 255); set_dir(1, 50, 100, 255);
    applyStimulus(2, 100, 0, 1'b1, 1'b0);
    checkOutput("pin_sub", {first_r, first_g, first_b}, {16'h0000, 16'h0000, 16'h9B9B});

    set_dir(0, 30, 60, 91); set_dir(1, 30, 60, 91);
    applyStimulus(3, 0, 0, 1'b1, 1'b0);
`ifdef GRAY_WEIGHTED_EN
    checkOutput("pin_gray", first_r, 16'h3636);
`else
    checkOutput("pin_gray", first_r, 16'h3C3C);
`endif

    set_dir(0, 90, 90, 90); set_dir(1, 91, 91, 91);
    applyStimulus(5, 0, 90, 1'b1, 1'b0);
    checkOutput("pin_thresh", {first_r, first_g, first_b}, {3{16'hFF00}});

    set_dir(0, 15, 15, 15); set_dir(1, 15, 15, 15);
    applyStimulus(4, 0, 0, 1'b1, 1'b0);
    checkOutput("pin_invert", first_g, 16'hF0F0);

    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++)
      applyStimulus(int'($urandom % 8), int'($urandom % 256), int'($urandom % 256), 1'b0, 1'b1);
    rand_ready = 1'b0;

    start_frame(0, 0, 0);
    for (int n = 0; n < 3; n++) send_beat(1'b0, 1'b0);
    @(posedge HCLK);
    #1;
    mon_en = 1'b0;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_zero_outputs("midreset");
    exp_q.delete();
    in_idx = 0;
    fd_pending = 1'b0;
    stalled_prev = 1'b0;
    mon_en = 1'b1;
    applyStimulus(4, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
